program_counter_stack: RTL and testbench

//  Parametrised program counter for the highRISC fetch stage; next generation of the 16-bit counter.

---
 rtl/program_counter_stack_if.sv | 32 +++
 rtl/program_counter_stack.sv | 102 ++++++++++
 tb/tb_program_counter_stack.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/program_counter_stack_if.sv
// Fetch-stage PC bus: decode-side controls into the counter and PC/stack status back out.
interface program_counter_stack_if #(
  parameter int WIDTH        = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int STACK_DEPTH  = 8
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic                    Stall;
  logic [WIDTH-1:0]        LoadValue;
  logic                    LoadEnable;
  logic [OFFSET_WIDTH-1:0] Offset;
  logic                    OffsetEnable;
  logic                    Call;
  logic                    Return;
  logic [WIDTH-1:0]        CounterValue;
  logic [CNT_W-1:0]        StackCount;
  logic                    StackEmpty;
  logic                    StackFull;
  logic                    Overflow;
  logic                    Underflow;

  modport master (
    output Stall, LoadValue, LoadEnable, Offset, OffsetEnable, Call, Return,
    input  CounterValue, StackCount, StackEmpty, StackFull, Overflow, Underflow
  );

  modport slave (
    input  Stall, LoadValue, LoadEnable, Offset, OffsetEnable, Call, Return,
    output CounterValue, StackCount, StackEmpty, StackFull, Overflow, Underflow
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with stall, relative branch, absolute load and a circular return-address stack.
// All actions are registered; one winning action per edge in fixed priority order.
module program_counter_stack #(
  parameter int               WIDTH        = 16,
  parameter int               OFFSET_WIDTH = 9,
  parameter int               STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  program_counter_stack_if.slave  bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] off_ext;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] wr_ptr_prev;
  logic             full;
  logic             empty;

  assign pc_inc  = pc_q + WIDTH'(1);
  assign off_ext = WIDTH'(signed'(bus.Offset));
  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);

  // wr_ptr points at the next free slot; the top entry sits one slot below it
  assign wr_ptr_next = (wr_ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign wr_ptr_prev = (wr_ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : wr_ptr_q - PTR_W'(1);

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    stack_d  = stack_q;

    if (bus.Stall) begin
      // hold everything
    end else if (bus.Call) begin
      // when full the write lands on the oldest entry, so depth stays saturated
      stack_d[wr_ptr_q] = pc_inc;
      wr_ptr_d          = wr_ptr_next;
      pc_d              = bus.LoadValue;
      if (full) ovf_d   = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (bus.Return) begin
      if (empty) begin
        pc_d  = pc_inc;
        udf_d = 1'b1;
      end else begin
        pc_d     = stack_q[wr_ptr_prev];
        wr_ptr_d = wr_ptr_prev;
        count_d  = count_q - CNT_W'(1);
      end
    end else if (bus.LoadEnable) begin
      pc_d = bus.LoadValue;
    end else if (bus.OffsetEnable) begin
      pc_d = pc_q + off_ext;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q     <= RESET_VALUE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // stack contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge Clock) begin
    stack_q <= stack_d;
  end

  assign bus.CounterValue = pc_q;
  assign bus.StackCount   = count_q;
  assign bus.StackEmpty   = empty;
  assign bus.StackFull    = full;
  assign bus.Overflow     = ovf_q;
  assign bus.Underflow    = udf_q;
endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack at WIDTH=16, OFFSET_WIDTH=9, STACK_DEPTH=8, RESET_VALUE=0.
module tb_program_counter_stack;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  program_counter_stack_if #(.WIDTH(16), .OFFSET_WIDTH(9), .STACK_DEPTH(8)) bus ();

  program_counter_stack #(
    .WIDTH(16), .OFFSET_WIDTH(9), .STACK_DEPTH(8), .RESET_VALUE(16'd0)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.Stall = 0; bus.LoadEnable = 0; bus.OffsetEnable = 0;
    bus.Call = 0; bus.Return = 0; bus.Offset = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.LoadValue = 16'd1000;
    rst = 1; step(1);
    n_cmp++; if (bus.CounterValue !== 16'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", bus.CounterValue); end
    n_cmp++; if (bus.StackCount !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.StackCount); end
    n_cmp++; if ({bus.StackEmpty, bus.StackFull, bus.Overflow, bus.Underflow} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=1000", {bus.StackEmpty, bus.StackFull, bus.Overflow, bus.Underflow}); end
    rst = 0; step(5);
    n_cmp++; if (bus.CounterValue !== 16'd5) begin n_fail++; $display("FAIL free_run got=%0d exp=5", bus.CounterValue); end
  endtask

  task automatic test_load_offset();
    step(5);
    n_cmp++; if (bus.CounterValue !== 16'd10) begin n_fail++; $display("FAIL pre_load got=%0d exp=10", bus.CounterValue); end
    bus.LoadEnable = 1; bus.OffsetEnable = 1; bus.Offset = 9'd7; step(1);
    bus.LoadEnable = 0; bus.OffsetEnable = 0;
    n_cmp++; if (bus.CounterValue !== 16'd1000) begin n_fail++; $display("FAIL load got=%0d exp=1000", bus.CounterValue); end
    step(1);
    n_cmp++; if (bus.CounterValue !== 16'd1001) begin n_fail++; $display("FAIL load_inc got=%0d exp=1001", bus.CounterValue); end
    step(4);
    bus.Offset = -9'sd200; bus.OffsetEnable = 1; step(1);
    n_cmp++; if (bus.CounterValue !== 16'd805) begin n_fail++; $display("FAIL offset_neg got=%0d exp=805", bus.CounterValue); end
    bus.Offset = 9'sd255; step(1);
    bus.OffsetEnable = 0;
    n_cmp++; if (bus.CounterValue !== 16'd1060) begin n_fail++; $display("FAIL offset_pos got=%0d exp=1060", bus.CounterValue); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'hFFFF; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0001;
    bus.LoadValue = 16'hFFFE; bus.LoadEnable = 1; step(1);
    bus.LoadEnable = 0;
    n_cmp++; if (bus.CounterValue !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_load got=%h exp=fffe", bus.CounterValue); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_cmp++; if (bus.CounterValue !== exp_seq[i]) begin n_fail++; $display("FAIL wrap_%0d got=%h exp=%h", i, bus.CounterValue, exp_seq[i]); end
    end
    bus.Offset = -9'sd2; bus.OffsetEnable = 1; step(1);
    bus.OffsetEnable = 0;
    n_cmp++; if (bus.CounterValue !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_offset got=%h exp=ffff", bus.CounterValue); end
  endtask

  task automatic test_call_return();
    bus.LoadValue = 16'd20; bus.LoadEnable = 1; step(1);
    bus.LoadEnable = 0;
    bus.LoadValue = 16'd500; bus.Call = 1; step(1);
    bus.Call = 0;
    n_cmp++; if (bus.CounterValue !== 16'd500 || bus.StackCount !== 4'd1) begin
      n_fail++; $display("FAIL call1 got pc=%0d cnt=%0d exp pc=500 cnt=1", bus.CounterValue, bus.StackCount); end
    step(3);
    bus.LoadValue = 16'd900; bus.Call = 1; step(1);
    bus.Call = 0;
    n_cmp++; if (bus.CounterValue !== 16'd900 || bus.StackCount !== 4'd2) begin
      n_fail++; $display("FAIL call2 got pc=%0d cnt=%0d exp pc=900 cnt=2", bus.CounterValue, bus.StackCount); end
    bus.Return = 1; bus.LoadEnable = 1; step(1);
    bus.LoadEnable = 0;
    n_cmp++; if (bus.CounterValue !== 16'd504 || bus.StackCount !== 4'd1) begin
      n_fail++; $display("FAIL ret1 got pc=%0d cnt=%0d exp pc=504 cnt=1", bus.CounterValue, bus.StackCount); end
    step(1);
    bus.Return = 0;
    n_cmp++; if (bus.CounterValue !== 16'd21 || bus.StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL ret2 got pc=%0d empty=%b exp pc=21 empty=1", bus.CounterValue, bus.StackEmpty); end
  endtask

  task automatic test_overflow_underflow();
    for (int k = 1; k <= 9; k++) begin
      bus.LoadValue = 16'(100 * k); bus.Call = 1; step(1);
      if (k == 8) begin
        n_cmp++; if (bus.StackFull !== 1'b1 || bus.Overflow !== 1'b0) begin
          n_fail++; $display("FAIL full8 got full=%b ovf=%b exp full=1 ovf=0", bus.StackFull, bus.Overflow); end
      end
    end
    bus.Call = 0;
    n_cmp++; if (bus.Overflow !== 1'b1 || bus.StackCount !== 4'd8) begin
      n_fail++; $display("FAIL ovf got ovf=%b cnt=%0d exp ovf=1 cnt=8", bus.Overflow, bus.StackCount); end
    bus.Return = 1;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      n_cmp++; if (bus.CounterValue !== 16'(100 * (9 - j) + 1)) begin
        n_fail++; $display("FAIL pop_%0d got=%0d exp=%0d", j, bus.CounterValue, 100 * (9 - j) + 1); end
    end
    step(1);
    bus.Return = 0;
    n_cmp++; if (bus.CounterValue !== 16'd102 || bus.Underflow !== 1'b1 || bus.StackCount !== 4'd0) begin
      n_fail++; $display("FAIL udf got pc=%0d udf=%b cnt=%0d exp pc=102 udf=1 cnt=0", bus.CounterValue, bus.Underflow, bus.StackCount); end
  endtask

  task automatic test_stall_and_reset();
    bus.LoadValue = 16'd50; bus.Call = 1; step(1);
    bus.Stall = 1; bus.LoadValue = 16'd777;
    step(3);
    bus.Stall = 0; bus.Call = 0;
    n_cmp++; if (bus.CounterValue !== 16'd50 || bus.StackCount !== 4'd1 || bus.Overflow !== 1'b1 || bus.Underflow !== 1'b1) begin
      n_fail++; $display("FAIL stall got pc=%0d cnt=%0d ovf=%b udf=%b exp pc=50 cnt=1 ovf=1 udf=1",
                         bus.CounterValue, bus.StackCount, bus.Overflow, bus.Underflow); end
    bus.LoadValue = 16'd300; bus.Call = 1; bus.Return = 1; step(1);
    bus.Return = 0;
    n_cmp++; if (bus.CounterValue !== 16'd300 || bus.StackCount !== 4'd2) begin
      n_fail++; $display("FAIL call_ret got pc=%0d cnt=%0d exp pc=300 cnt=2", bus.CounterValue, bus.StackCount); end
    bus.LoadValue = 16'd400; step(1);
    bus.Call = 0;
    n_cmp++; if (bus.StackCount !== 4'd3) begin n_fail++; $display("FAIL cnt3 got=%0d exp=3", bus.StackCount); end
    rst = 1; bus.Return = 1; step(1);
    rst = 0; bus.Return = 0;
    n_cmp++; if (bus.CounterValue !== 16'd0 || bus.StackCount !== 4'd0 ||
                 {bus.StackEmpty, bus.StackFull, bus.Overflow, bus.Underflow} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid got pc=%0d cnt=%0d flags=%b exp pc=0 cnt=0 flags=1000",
                         bus.CounterValue, bus.StackCount, {bus.StackEmpty, bus.StackFull, bus.Overflow, bus.Underflow}); end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_load_offset();
    test_wrap();
    test_call_return();
    test_overflow_underflow();
    test_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
